// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and default parameters.
package cpu_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned STEP_DEFAULT     = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHoldRedir
    } pc_state_e;

endpackage

// File: rtl/pc_inc.sv
// Sequential PC incrementer: pc + STEP, wrapping modulo 2^XLEN.
module pc_inc #(
    parameter int unsigned XLEN = cpu_pkg::XLEN_DEFAULT,
    parameter int unsigned STEP = cpu_pkg::STEP_DEFAULT
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_inc_o
);

    assign pc_inc_o = pc_i + XLEN'(STEP);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot, sequential advance, stall hold and redirects that
// may be parked while stalled.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     STEP     = STEP_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_seq_o,
    output logic            fetch_valid_o,
    output logic            redirect_pending_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] LowMask = XLEN'(STEP - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            fetch_valid_q;
    logic            pending_q;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] tgt_aligned;
    logic            tgt_low_nz;

    pc_inc #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_pc_inc (
        .pc_i     (pc_q),
        .pc_inc_o (pc_seq)
    );

    // With STEP = 1 the mask is zero, so nothing is cleared and nothing flags.
    assign tgt_aligned = redirect_target_i & ~LowMask;
    assign tgt_low_nz  = |(redirect_target_i & LowMask);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        misalign_d = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (stall_i) begin
                    if (redirect_valid_i) begin
                        tgt_d      = tgt_aligned;
                        misalign_d = tgt_low_nz;
                        state_d    = StHoldRedir;
                    end
                end else if (redirect_valid_i) begin
                    pc_d       = tgt_aligned;
                    misalign_d = tgt_low_nz;
                end else begin
                    pc_d = pc_seq;
                end
            end
            StHoldRedir: begin
                if (stall_i) begin
                    if (redirect_valid_i) begin
                        tgt_d      = tgt_aligned;
                        misalign_d = tgt_low_nz;
                    end
                end else begin
                    state_d = StRun;
                    tgt_d   = '0;
                    if (redirect_valid_i) begin
                        pc_d       = tgt_aligned;
                        misalign_d = tgt_low_nz;
                    end else begin
                        pc_d = tgt_q;
                    end
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            tgt_q         <= '0;
            fetch_valid_q <= 1'b0;
            pending_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            fetch_valid_q <= (state_d != StBoot);
            pending_q     <= (state_d == StHoldRedir);
            misalign_q    <= misalign_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_next_seq_o      = pc_seq;
    assign fetch_valid_o      = fetch_valid_q;
    assign redirect_pending_o = pending_q;
    assign misalign_o         = misalign_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, sets the width of the PC and every address port.
REQ-002 Parameter STEP, default 4, is the sequential increment in bytes; it SHALL be a power of two, with 1 <= STEP <= 2^(XLEN-1).
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded on reset; it SHALL be a multiple of STEP.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold the current PC; no sequential advance.
REQ-007 redirect_valid  in  1  branch/jump resolved; load redirect_target.
REQ-008 redirect_target  in  XLEN  redirect destination address.
REQ-009 pc  out  XLEN  registered fetch address.
REQ-010 pc_next_seq  out  XLEN  combinational pc + STEP, modulo 2^XLEN.
REQ-011 fetch_valid  out  1  registered; pc is a legitimate fetch address this cycle.
REQ-012 redirect_pending  out  1  registered; a redirect is latched and waiting for the stall to release.
REQ-013 misalign  out  1  registered one-cycle pulse; the last accepted redirect_target was not STEP-aligned.

Function
REQ-014 The FSM SHALL have exactly three states: BOOT, RUN and HOLD_REDIR.
REQ-015 BOOT: pc = RESET_PC, fetch_valid = 0; the FSM SHALL go to RUN on the next edge unconditionally, and pc SHALL NOT change on that edge.
REQ-016 RUN, redirect_valid = 1, stall = 0: pc <= aligned target on the next edge.
REQ-017 RUN, redirect_valid = 0, stall = 0: pc <= pc + STEP, modulo 2^XLEN (wraps to 0, no flag).
REQ-018 RUN, stall = 1, redirect_valid = 0: pc SHALL hold.
REQ-019 RUN, stall = 1, redirect_valid = 1: pc SHALL hold, the aligned target SHALL be latched internally, and the FSM SHALL go to HOLD_REDIR.
REQ-020 HOLD_REDIR, stall = 1: pc SHALL hold; a new redirect_valid SHALL overwrite the latched target (the latest redirect wins).
REQ-021 HOLD_REDIR, stall = 0, redirect_valid = 0: pc <= latched target and the FSM SHALL go to RUN.
REQ-022 HOLD_REDIR, stall = 0, redirect_valid = 1: pc <= the live aligned target, the latched target SHALL be discarded, and the FSM SHALL go to RUN.
REQ-023 Alignment: the aligned target is redirect_target with its low log2(STEP) bits cleared; when STEP = 1 no bits are cleared.
REQ-024 misalign SHALL be 1 in the cycle after any accepted redirect (whether applied or latched) whose cleared bits were nonzero, and 0 otherwise.
REQ-025 fetch_valid SHALL be 1 in every state except BOOT; it is 1 while stalled.
REQ-026 redirect_pending SHALL be 1 exactly when the FSM is in HOLD_REDIR.
REQ-027 In BOOT, stall and redirect_valid SHALL be ignored.
REQ-028 Latency: redirect to pc is 1 cycle when not stalled; otherwise it is 1 cycle after stall falls.

Reset
REQ-029 While rstn = 0, the block SHALL asynchronously force pc = RESET_PC, state = BOOT, latched target = 0, fetch_valid = 0, redirect_pending = 0 and misalign = 0.
REQ-030 A reset asserted mid-operation, including in HOLD_REDIR, SHALL drop any pending redirect.
REQ-031 Release of rstn SHALL be treated as synchronous to clk; the first edge after release is the BOOT -> RUN edge.

Structure
REQ-032 The FSM state enum and the default values of XLEN, STEP and RESET_PC SHALL live in the shared package cpu_pkg.
REQ-033 The incrementer SHALL be the sub-module pc_inc (XLEN, STEP; combinational pc + STEP), instantiated once and also driving pc_next_seq.
REQ-034 pc_gen SHALL be the sole owner of the PC register in the pipeline.

Verification
REQ-035 Reset/boot (defaults): release rstn -> pc = 0x0 with fetch_valid = 0 for one cycle, then pc = 0x0, 0x4, 0x8 with fetch_valid = 1.
REQ-036 Redirect, no stall: pc = 0x10, redirect_valid = 1, target 0x100 -> next pc = 0x100, then 0x104.
REQ-037 Redirect under stall: pc = 0x20, stall held 3 cycles, redirect to 0x200 in the first and to 0x300 in the second -> pc stays 0x20 and redirect_pending = 1; one cycle after stall falls pc = 0x300.
REQ-038 Simultaneous release: in HOLD_REDIR with latched 0x300, stall = 0 together with redirect to 0x400 -> pc = 0x400 and the latched target is discarded.
REQ-039 Misalign/wrap: redirect to 0x103 -> pc = 0x100 and misalign pulses for 1 cycle; redirect to 0xFFFF_FFFC -> pc then goes 0xFFFF_FFFC, 0x0.
REQ-040 Async reset in HOLD_REDIR: assert rstn = 0 between clock edges -> pc = RESET_PC immediately and redirect_pending = 0; the pending target is never applied.
